// File: rtl/stack_machine_pkg.sv
// Shared types and constants for the 20-bit signed stack machine.
package stack_machine_pkg;

    localparam int DATA_W = 20;
    localparam int IMM_W  = 10;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_POP  = 3'b100,
        OP_TOP  = 3'b101,
        OP_RSVD = 3'b110,
        OP_END  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_OVERFLOW  = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_ILLEGAL   = 3'd3,
        ERR_ARITH     = 3'd4
    } err_t;

    typedef enum logic [1:0] {
        STK_NOP,
        STK_PUSH,
        STK_POP,
        STK_REPLACE2
    } stk_op_t;

    // True when a double-width result is representable in DATA_W signed bits.
    function automatic logic fits_data(input logic signed [2*DATA_W-1:0] v);
        return (v[2*DATA_W-1:DATA_W-1] == '0) || (v[2*DATA_W-1:DATA_W-1] == '1);
    endfunction

endpackage

// File: rtl/sm_stack.sv
// LIFO register file with push, pop and replace-top-two operations.
module sm_stack
    import stack_machine_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  stk_op_t                  op,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] top,
    output logic signed [DATA_W-1:0] second,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty
);

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] second_idx;
    logic             has_two;

    assign push_idx   = IDX_W'(count);
    assign top_idx    = IDX_W'(count - CNT_W'(1));
    assign second_idx = IDX_W'(count - CNT_W'(2));
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign has_two    = (count >= CNT_W'(2));

    assign top    = empty   ? '0 : mem[top_idx];
    assign second = has_two ? mem[second_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case (op)
                STK_PUSH:     if (!full)   count <= count + CNT_W'(1);
                STK_POP:      if (!empty)  count <= count - CNT_W'(1);
                STK_REPLACE2: if (has_two) count <= count - CNT_W'(1);
                default:      ;
            endcase
        end
    end

    // Contents need no reset: entries at or above count are never read.
    always_ff @(posedge clk) begin
        case (op)
            STK_PUSH:     if (!full)   mem[push_idx]   <= wdata;
            STK_REPLACE2: if (has_two) mem[second_idx] <= wdata;
            default:      ;
        endcase
    end

endmodule

// File: rtl/stack_machine.sv
// Single-issue stack machine: fetch by pc, execute combinationally, commit on the edge.
module stack_machine
    import stack_machine_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OP_W+IMM_W-1:0]   instr,
    output logic [PC_W-1:0]         pc,
    output logic                    d_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [2:0]              err_code,
    output logic                    fin
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    opcode_t                    op;
    logic signed [DATA_W-1:0]   imm_ext;
    logic signed [DATA_W-1:0]   top;
    logic signed [DATA_W-1:0]   second;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic signed [2*DATA_W-1:0] a_w;
    logic signed [2*DATA_W-1:0] b_w;
    logic signed [2*DATA_W-1:0] alu_wide;
    stk_op_t                    stk_op;
    logic signed [DATA_W-1:0]   wdata;
    logic signed [DATA_W-1:0]   res;
    err_t                       err;
    logic                       is_end;

    assign op      = opcode_t'(instr[OP_W+IMM_W-1:IMM_W]);
    assign imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign d_valid = !fin && !$isunknown(instr);

    // Double-width operands make the arithmetic exact so overflow is a range test.
    assign a_w = {{DATA_W{second[DATA_W-1]}}, second};
    assign b_w = {{DATA_W{top[DATA_W-1]}}, top};

    always_comb begin
        case (op)
            OP_ADD:  alu_wide = a_w + b_w;
            OP_SUB:  alu_wide = a_w - b_w;
            OP_MUL:  alu_wide = a_w * b_w;
            default: alu_wide = '0;
        endcase
    end

    always_comb begin
        stk_op = STK_NOP;
        wdata  = '0;
        res    = '0;
        err    = ERR_NONE;
        is_end = 1'b0;
        if (d_valid) begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        err = ERR_OVERFLOW;
                    end else begin
                        stk_op = STK_PUSH;
                        wdata  = imm_ext;
                        res    = imm_ext;
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (count < CNT_W'(2)) begin
                        err = ERR_UNDERFLOW;
                    end else if (!fits_data(alu_wide)) begin
                        err = ERR_ARITH;
                    end else begin
                        stk_op = STK_REPLACE2;
                        wdata  = alu_wide[DATA_W-1:0];
                        res    = alu_wide[DATA_W-1:0];
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        err = ERR_UNDERFLOW;
                    end else begin
                        stk_op = STK_POP;
                        res    = top;
                    end
                end
                OP_TOP: begin
                    if (empty) err = ERR_UNDERFLOW;
                    else       res = top;
                end
                OP_END:  is_end = 1'b1;
                default: err = ERR_ILLEGAL;
            endcase
        end
    end

    assign out_data = res;
    assign err_code = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            fin <= 1'b0;
        end else if (!fin) begin
            if (is_end) fin <= 1'b1;
            else        pc  <= pc + PC_W'(1);
        end
    end

    sm_stack #(.DEPTH(DEPTH)) u_stack (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (stk_op),
        .wdata  (wdata),
        .top    (top),
        .second (second),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_stack_machine.sv
// Scoreboard bench for stack_machine: programs from a bench ROM, expected results queued per instruction.
module tb_stack_machine;
    import stack_machine_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] instr;
    logic [9:0]  pc;
    logic        d_valid;
    logic [19:0] out_data;
    logic [2:0]  err_code;
    logic        fin;

    logic [12:0] rom [1024];
    logic        ovr_en = 1'b0;
    logic [12:0] ovr_instr = '0;
    logic        mon_en = 1'b0;

    typedef struct {
        int pc;
        int err;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   prog_len = 0;

    assign instr = ovr_en ? ovr_instr : rom[pc];

    stack_machine #(.DEPTH(8), .PC_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .pc       (pc),
        .d_valid  (d_valid),
        .out_data (out_data),
        .err_code (err_code),
        .fin      (fin)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] enc(input logic [2:0] op, input int imm);
        logic [9:0] i10;
        i10 = imm[9:0];
        return {op, i10};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_prog(input logic [12:0] fill);
        for (int i = 0; i < 1024; i++) rom[i] = fill;
        exp_q.delete();
        prog_len = 0;
    endtask

    task automatic add(input logic [2:0] op, input int imm, input int err, input int data);
        exp_t e;
        rom[prog_len] = enc(op, imm);
        e.pc   = prog_len;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
        prog_len++;
    endtask

    // Monitor: every valid output cycle consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n && d_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: pc %0d err %0d data %0d", pc, err_code, $signed(out_data));
            end else begin
                e = exp_q.pop_front();
                check("pc", int'(pc), e.pc);
                check("err", int'(err_code), e.err);
                check("data", int'($signed(out_data)), e.data);
            end
        end
    end

    task automatic run_prog(input int end_pc);
        int budget;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("reset_pc", int'(pc), 0);
        check("reset_fin", int'(fin), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        check("timeout_remaining", exp_q.size(), 0);
        #1;
        mon_en = 1'b0;
        check("fin_after_end", int'(fin), 1);
        check("pc_at_end", int'(pc), end_pc);
        check("d_valid_after_end", int'(d_valid), 0);
        check("data_after_end", int'(out_data), 0);
        repeat (3) @(posedge clk);
        #1;
        check("pc_holds", int'(pc), end_pc);
        check("fin_sticky", int'(fin), 1);
        check("d_valid_stays_low", int'(d_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program 1: basic push/add, depth-1 check, END at pc 6.
        new_prog(enc(OP_END, 0));
        add(OP_PUSH,  5, 0,  5);
        add(OP_PUSH, -3, 0, -3);
        add(OP_ADD,   0, 0,  2);
        add(OP_TOP,   0, 0,  2);
        add(OP_POP,   0, 0,  2);
        add(OP_POP,   0, 2,  0);
        add(OP_END,   0, 0,  0);
        run_prog(6);

        // Program 2 is loaded while fin=1, then reset asynchronously.
        new_prog(enc(OP_END, 0));
        add(OP_PUSH,   7, 0, 7);
        add(OP_PUSH,  10, 0, 10);
        add(OP_SUB,    0, 0, -3);
        add(OP_PUSH, 300, 0, 300);
        add(OP_PUSH, 400, 0, 400);
        add(OP_MUL,    0, 0, 120000);
        add(OP_POP,    0, 0, 120000);
        add(OP_POP,    0, 0, -3);
        add(OP_POP,    0, 2, 0);
        add(OP_ADD,    0, 2, 0);
        add(OP_RSVD,   0, 3, 0);
        add(OP_END,    0, 0, 0);

        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", int'(pc), 0);
        check("async_reset_fin", int'(fin), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_prog_pc", int'(pc), 3);
        #1;
        rst_n     = 1'b0;
        ovr_en    = 1'b1;
        ovr_instr = enc(OP_POP, 0);
        #1;
        check("mid_reset_pc", int'(pc), 0);
        check("mid_reset_valid", int'(d_valid), 1);
        check("mid_reset_empty_err", int'(err_code), 2);
        check("mid_reset_data", int'(out_data), 0);
        ovr_en = 1'b0;
        run_prog(11);

        // Program 3: arithmetic overflow and full-stack boundary.
        new_prog(enc(OP_END, 0));
        add(OP_PUSH, 511, 0, 511);
        add(OP_PUSH, 511, 0, 511);
        add(OP_MUL,    0, 0, 261121);
        add(OP_PUSH, 511, 0, 511);
        add(OP_MUL,    0, 4, 0);
        add(OP_PUSH, 511, 0, 511);
        add(OP_MUL,    0, 0, 261121);
        add(OP_TOP,    0, 0, 261121);
        add(OP_POP,    0, 0, 261121);
        add(OP_POP,    0, 0, 261121);
        for (int v = 1; v <= 7; v++) add(OP_PUSH, v, 0, v);
        add(OP_PUSH, -512, 0, -512);
        add(OP_PUSH,  511, 1, 0);
        add(OP_TOP,     0, 0, -512);
        add(OP_END,     0, 0, 0);
        run_prog(20);

        // pc wraps 1023 -> 0 on a ROM full of harmless TOP-on-empty.
        new_prog(enc(OP_TOP, 0));
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (1025) @(posedge clk);
        #1;
        check("pc_wrap", int'(pc), 1);
        check("wrap_err", int'(err_code), 2);
        check("wrap_fin", int'(fin), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_machine.md
Name: stack_machine

Overview:
- Single-issue 20-bit signed stack machine. It fetches one 13-bit instruction per clock from an external instruction memory addressed by its own program counter.
- Each cycle it executes that instruction against an internal LIFO stack and reports the result, an error code and a valid strobe in the same cycle.
- It stops on END and raises fin.
- It sits between an instruction ROM (1024 words) and a result checker/consumer.

Parameters:
- DEPTH, 8, number of stack entries (each 20-bit signed).
- PC_W, 10, program counter width (1024-word instruction space).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low, asynchronous.
- instr  in  13  instruction at address pc; [12:10] opcode, [9:0] signed immediate.
- pc  out  10  registered address of the instruction being executed this cycle.
- d_valid  out  1  current instruction's result/error outputs are valid.
- out_data  out  20  signed result of the current instruction.
- err_code  out  3  error status of the current instruction.
- fin  out  1  program finished; sticky until reset.

Behaviour:
- Interfaces:
  - Single clock domain (clk); reset rst_n is asynchronous and active-low.
  - Reset: pc=0, stack empty (sp=0), fin=0.
- Timing:
  - Execute/report is combinational on instr and current stack state: d_valid, out_data and err_code are valid throughout the cycle in which pc addresses instr.
  - These outputs must be stable before the rising edge.
  - State (stack, sp, pc, fin) updates on the rising edge.
  - pc increments by 1 every cycle while fin=0; it wraps 1023->0.
- d_valid:
  - d_valid=1 for every cycle with fin=0 and instr free of X/Z.
  - d_valid=0 while fin=1.
  - out_data=0 whenever d_valid=0 or err_code!=0.
- Opcodes:
  - 000 PUSH: push sign-extended imm[9:0]; out_data = pushed value. Full stack -> err 1, stack unchanged.
  - 001 ADD, 010 SUB, 011 MUL:
    - Operands a = entry below top, b = top; pop both, push result.
    - ADD = a+b, SUB = a-b, MUL = a*b.
    - out_data = result. Fewer than 2 entries -> err 2, stack unchanged.
    - If the exact result does not fit in 20-bit signed -> err 4, stack unchanged, out_data=0.
  - 100 POP: pop top; out_data = popped value. Empty stack -> err 2.
  - 101 TOP: out_data = top, stack unchanged. Empty stack -> err 2.
  - 111 END: err 0, out_data=0. fin goes 1 at the next edge; pc holds its value thereafter.
  - 110 reserved: err 3, no state change.
- Error encoding: 0 ok, 1 overflow (push on full), 2 underflow, 3 illegal opcode, 4 arithmetic overflow.
- Error priority: illegal opcode > stack underflow/overflow > arithmetic overflow.
- Any error leaves stack contents and sp unchanged; pc still advances.
- Reset asserted mid-program clears everything asynchronously; execution restarts at pc=0 after release.

Decomposition:
- Package stack_machine_pkg: opcode constants (OP_PUSH…OP_END), error-code constants, DATA_W=20, IMM_W=10.
- One sub-module, sm_stack:
  - DEPTH×20 register file with sp.
  - Push/pop/replace-top-two operation port.
  - full/empty/count flags.
- Top-level stack_machine keeps pc, fin, decode, ALU and error logic.

Test Plan:
- PUSH 5, PUSH -3, ADD -> out_data 5, -3, then 2, err 0, d_valid 1 each cycle; final depth 1.
- PUSH 7, PUSH 10, SUB; PUSH 300, PUSH 400, MUL -> SUB gives -3; MUL gives 120000.
- PUSH 511, PUSH 511, MUL, PUSH 511, MUL, PUSH 511, MUL -> 261121, then 133432831 overflows 20 bits: err 4, stack unchanged.
- Checks on empty stack:
  - ADD on empty stack -> err 2.
  - Nine consecutive PUSH with DEPTH=8 -> ninth err 1.
  - POP on empty -> err 2.
  - Opcode 110 -> err 3.
- END at pc=6 -> fin=1 at next edge, pc holds 6, d_valid=0 afterwards.
- Assert rst_n mid-program -> pc=0, fin=0, stack empty immediately, without waiting for a clock edge.
